// File: rtl/commit_stage.sv
// Retirement stage behind the scoreboard: retires the in-order head, releases stores,
// sequences CSR ops and raises precise exceptions, one instruction per cycle at most.
module commit_stage #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned NR_SB_ENTRIES = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             halt_i,
  input  logic                             commit_valid_i,
  input  logic                             commit_done_i,
  input  logic [$clog2(NR_SB_ENTRIES)-1:0] commit_id_i,
  input  logic [2:0]                       commit_fu_i,
  input  logic [4:0]                       commit_rd_i,
  input  logic [XLEN-1:0]                  commit_result_i,
  input  logic [XLEN-1:0]                  commit_pc_i,
  input  logic                             commit_ex_valid_i,
  input  logic [XLEN-1:0]                  commit_ex_cause_i,
  input  logic [XLEN-1:0]                  commit_ex_tval_i,
  output logic                             commit_ack_o,
  output logic                             we_o,
  output logic [4:0]                       waddr_o,
  output logic [XLEN-1:0]                  wdata_o,
  output logic                             commit_store_o,
  input  logic                             commit_store_ready_i,
  output logic                             csr_commit_o,
  input  logic                             csr_ack_i,
  input  logic [XLEN-1:0]                  csr_rdata_i,
  output logic                             ex_valid_o,
  output logic [XLEN-1:0]                  ex_cause_o,
  output logic [XLEN-1:0]                  ex_tval_o,
  output logic [XLEN-1:0]                  ex_pc_o,
  output logic                             flush_req_o,
  output logic [63:0]                      instret_o
);

  typedef enum logic [1:0] {COMMIT, WAIT_CSR, FLUSH} state_e;

  localparam logic [2:0] FU_STORE = 3'd3;
  localparam logic [2:0] FU_CSR   = 3'd4;

  state_e state;
  logic   ready;
  logic   ack_raw;
  logic   trace_unused;

  // The slot index is carried for tracing only.
  assign trace_unused = ^commit_id_i;

  assign ready = commit_valid_i & commit_done_i & ~halt_i & ~flush_i;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    ack_raw        = 1'b0;
    we_o           = 1'b0;
    waddr_o        = '0;
    wdata_o        = '0;
    commit_store_o = 1'b0;
    csr_commit_o   = 1'b0;
    ex_valid_o     = 1'b0;
    ex_cause_o     = '0;
    ex_tval_o      = '0;
    ex_pc_o        = '0;
    flush_req_o    = 1'b0;
    if (!rst_i && !flush_i) begin
      case (state)
        COMMIT: begin
          if (ready) begin
            if (commit_ex_valid_i) begin
              ex_valid_o  = 1'b1;
              ex_cause_o  = commit_ex_cause_i;
              ex_tval_o   = commit_ex_tval_i;
              ex_pc_o     = commit_pc_i;
              ack_raw     = 1'b1;
              flush_req_o = 1'b1;
            end else if (commit_fu_i == FU_STORE) begin
              commit_store_o = 1'b1;
              ack_raw        = commit_store_ready_i;
            end else if (commit_fu_i == FU_CSR) begin
              csr_commit_o = 1'b1;
            end else begin
              we_o    = (commit_rd_i != 5'd0);
              waddr_o = commit_rd_i;
              wdata_o = commit_result_i;
              ack_raw = 1'b1;
            end
          end
        end
        WAIT_CSR: begin
          if (csr_ack_i) begin
            we_o        = (commit_rd_i != 5'd0);
            waddr_o     = commit_rd_i;
            wdata_o     = csr_rdata_i;
            ack_raw     = 1'b1;
            flush_req_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // The head slot is only freed while the scoreboard still presents it.
    commit_ack_o = ack_raw & commit_valid_i;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state     <= COMMIT;
      instret_o <= '0;
    end else begin
      if (commit_ack_o && !ex_valid_o)
        instret_o <= instret_o + 64'd1;
      if (flush_i) begin
        state <= COMMIT;
      end else begin
        case (state)
          COMMIT: begin
            if (ready && commit_ex_valid_i)
              state <= FLUSH;
            else if (ready && commit_fu_i == FU_CSR)
              state <= WAIT_CSR;
          end
          WAIT_CSR: if (csr_ack_i) state <= FLUSH;
          default:  state <= COMMIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// Directed bench for commit_stage: a transaction-level retirement model is compared every
// cycle, and hand-computed literal expectations pin the model at key points.
module tb_commit_stage;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NR_SB_ENTRIES = 8;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            halt_i = 1'b0;
  logic            commit_valid_i = 1'b0;
  logic            commit_done_i = 1'b0;
  logic [2:0]      commit_id_i = '0;
  logic [2:0]      commit_fu_i = '0;
  logic [4:0]      commit_rd_i = '0;
  logic [XLEN-1:0] commit_result_i = '0;
  logic [XLEN-1:0] commit_pc_i = '0;
  logic            commit_ex_valid_i = 1'b0;
  logic [XLEN-1:0] commit_ex_cause_i = '0;
  logic [XLEN-1:0] commit_ex_tval_i = '0;
  logic            commit_store_ready_i = 1'b0;
  logic            csr_ack_i = 1'b0;
  logic [XLEN-1:0] csr_rdata_i = '0;

  logic            commit_ack_o, we_o, commit_store_o, csr_commit_o, ex_valid_o, flush_req_o;
  logic [4:0]      waddr_o;
  logic [XLEN-1:0] wdata_o, ex_cause_o, ex_tval_o, ex_pc_o;
  logic [63:0]     instret_o;

  int n_checks = 0;
  int n_errors = 0;

  commit_stage #(.XLEN(XLEN), .NR_SB_ENTRIES(NR_SB_ENTRIES)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .halt_i(halt_i),
    .commit_valid_i(commit_valid_i), .commit_done_i(commit_done_i),
    .commit_id_i(commit_id_i), .commit_fu_i(commit_fu_i), .commit_rd_i(commit_rd_i),
    .commit_result_i(commit_result_i), .commit_pc_i(commit_pc_i),
    .commit_ex_valid_i(commit_ex_valid_i), .commit_ex_cause_i(commit_ex_cause_i),
    .commit_ex_tval_i(commit_ex_tval_i), .commit_ack_o(commit_ack_o), .we_o(we_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .commit_store_o(commit_store_o),
    .commit_store_ready_i(commit_store_ready_i), .csr_commit_o(csr_commit_o),
    .csr_ack_i(csr_ack_i), .csr_rdata_i(csr_rdata_i), .ex_valid_o(ex_valid_o),
    .ex_cause_o(ex_cause_o), .ex_tval_o(ex_tval_o), .ex_pc_o(ex_pc_o),
    .flush_req_o(flush_req_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Retirement model: a CSR op in flight, a one-cycle bubble after a flush request,
  // and a count of retired instructions.
  bit              m_csr_pending = 1'b0;
  bit              m_bubble = 1'b0;
  longint unsigned m_count = 0;

  initial begin
    @(posedge clk);
    forever begin
      logic e_ack, e_we, e_store, e_csr, e_ex, e_fr;
      logic [4:0]  e_waddr;
      logic [63:0] e_wdata, e_cause, e_tval, e_pc;
      bit head_ok, retired, to_bubble, to_pending, csr_done;
      @(negedge clk);
      {e_ack, e_we, e_store, e_csr, e_ex, e_fr} = '0;
      e_waddr = '0; e_wdata = '0; e_cause = '0; e_tval = '0; e_pc = '0;
      {retired, to_bubble, to_pending, csr_done} = '0;
      head_ok = commit_valid_i && commit_done_i && !halt_i;
      if (!rst_i && !flush_i && !m_bubble) begin
        if (m_csr_pending) begin
          if (csr_ack_i) begin
            e_we = (commit_rd_i != 0); e_waddr = commit_rd_i; e_wdata = csr_rdata_i;
            e_fr = 1'b1; e_ack = commit_valid_i; retired = commit_valid_i;
            csr_done = 1'b1;
          end
        end else if (head_ok) begin
          if (commit_ex_valid_i) begin
            e_ex = 1'b1; e_cause = commit_ex_cause_i; e_tval = commit_ex_tval_i;
            e_pc = commit_pc_i; e_ack = 1'b1; e_fr = 1'b1; to_bubble = 1'b1;
          end else if (commit_fu_i == 3'd3) begin
            e_store = 1'b1; e_ack = commit_store_ready_i; retired = commit_store_ready_i;
          end else if (commit_fu_i == 3'd4) begin
            e_csr = 1'b1; to_pending = 1'b1;
          end else begin
            e_we = (commit_rd_i != 0); e_waddr = commit_rd_i; e_wdata = commit_result_i;
            e_ack = 1'b1; retired = 1'b1;
          end
        end
      end
      check("ack", commit_ack_o, e_ack);
      check("we", we_o, e_we);
      check("waddr", waddr_o, e_waddr);
      check("wdata", wdata_o, e_wdata);
      check("store", commit_store_o, e_store);
      check("csr_commit", csr_commit_o, e_csr);
      check("ex_valid", ex_valid_o, e_ex);
      check("ex_cause", ex_cause_o, e_cause);
      check("ex_tval", ex_tval_o, e_tval);
      check("ex_pc", ex_pc_o, e_pc);
      check("flush_req", flush_req_o, e_fr);
      check("instret", instret_o, m_count);
      if (rst_i) begin
        m_csr_pending = 1'b0; m_bubble = 1'b0; m_count = 0;
      end else if (flush_i) begin
        m_csr_pending = 1'b0; m_bubble = 1'b0;
      end else begin
        if (retired) m_count = m_count + 1;
        if (m_bubble) m_bubble = 1'b0;
        else if (csr_done) begin m_csr_pending = 1'b0; m_bubble = 1'b1; end
        else if (to_bubble) m_bubble = 1'b1;
        else if (to_pending) m_csr_pending = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input logic [2:0] fu, input logic [4:0] rd, input logic [63:0] res);
    commit_valid_i = 1'b1; commit_done_i = 1'b1;
    commit_fu_i = fu; commit_rd_i = rd; commit_result_i = res;
    commit_id_i = commit_id_i + 3'd1;
  endtask

  initial begin
    tick();
    tick();
    check("rst_instret", instret_o, 64'd0);
    check("rst_ack", commit_ack_o, 1'b0);

    // ALU retire rd=5, then rd=0.
    tick(); rst_i = 1'b0; head(3'd0, 5'd5, 64'hDEAD); #1;
    check("alu_we", we_o, 1'b1);
    check("alu_waddr", waddr_o, 64'd5);
    check("alu_wdata", wdata_o, 64'hDEAD);
    check("alu_ack", commit_ack_o, 1'b1);
    tick(); head(3'd0, 5'd0, 64'h55); #1;
    check("alu_instret1", instret_o, 64'd1);
    check("rd0_ack", commit_ack_o, 1'b1);
    check("rd0_we", we_o, 1'b0);

    // Store held off by the LSU for three cycles.
    tick(); head(3'd3, 5'd2, 64'h99); commit_store_ready_i = 1'b0; #1;
    check("rd0_instret2", instret_o, 64'd2);
    for (int i = 0; i < 3; i++) begin
      check("st_wait_store", commit_store_o, 1'b1);
      check("st_wait_ack", commit_ack_o, 1'b0);
      check("st_wait_we", we_o, 1'b0);
      tick(); #1;
    end
    commit_store_ready_i = 1'b1; #1;
    check("st_store", commit_store_o, 1'b1);
    check("st_ack", commit_ack_o, 1'b1);
    check("st_we", we_o, 1'b0);

    // CSR rd=7 acked after two wait cycles.
    tick(); commit_store_ready_i = 1'b0; head(3'd4, 5'd7, 64'h0); #1;
    check("st_instret3", instret_o, 64'd3);
    check("csr_req", csr_commit_o, 1'b1);
    check("csr_req_ack", commit_ack_o, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("csr_wait_req", csr_commit_o, 1'b0);
      check("csr_wait_ack", commit_ack_o, 1'b0);
    end
    tick(); csr_ack_i = 1'b1; csr_rdata_i = 64'h1234; #1;
    check("csr_we", we_o, 1'b1);
    check("csr_waddr", waddr_o, 64'd7);
    check("csr_wdata", wdata_o, 64'h1234);
    check("csr_ack", commit_ack_o, 1'b1);
    check("csr_flush_req", flush_req_o, 1'b1);
    tick(); csr_ack_i = 1'b0; head(3'd0, 5'd9, 64'h77); #1;
    check("csr_bubble_ack", commit_ack_o, 1'b0);
    check("csr_bubble_we", we_o, 1'b0);
    check("csr_instret4", instret_o, 64'd4);

    // Exception head: dropped, no write, no count.
    tick(); head(3'd0, 5'd3, 64'h1);
    commit_ex_valid_i = 1'b1; commit_ex_cause_i = 64'd2;
    commit_pc_i = 64'h8000_0010; commit_ex_tval_i = 64'hBAD; #1;
    check("ex_valid", ex_valid_o, 1'b1);
    check("ex_cause", ex_cause_o, 64'd2);
    check("ex_pc", ex_pc_o, 64'h8000_0010);
    check("ex_tval", ex_tval_o, 64'hBAD);
    check("ex_ack", commit_ack_o, 1'b1);
    check("ex_flush_req", flush_req_o, 1'b1);
    check("ex_we", we_o, 1'b0);
    tick(); commit_ex_valid_i = 1'b0; head(3'd0, 5'd9, 64'h77); #1;
    check("ex_bubble_ack", commit_ack_o, 1'b0);
    check("ex_bubble_ex", ex_valid_o, 1'b0);
    check("ex_instret4", instret_o, 64'd4);
    tick(); #1;
    check("post_ex_we", we_o, 1'b1);
    check("post_ex_waddr", waddr_o, 64'd9);

    // Not-done head and halt block retirement.
    tick(); commit_done_i = 1'b0; #1;
    check("notdone_ack", commit_ack_o, 1'b0);
    check("post_ex_instret5", instret_o, 64'd5);
    tick(); commit_done_i = 1'b1; halt_i = 1'b1; #1;
    check("halt_ack", commit_ack_o, 1'b0);
    check("halt_we", we_o, 1'b0);
    tick(); halt_i = 1'b0; commit_valid_i = 1'b0; #1;
    check("invalid_ack", commit_ack_o, 1'b0);

    // Flush abandons WAIT_CSR; the next head retires at once.
    tick(); head(3'd4, 5'd6, 64'h0); #1;
    check("csr2_req", csr_commit_o, 1'b1);
    tick(); flush_i = 1'b1; csr_ack_i = 1'b1; csr_rdata_i = 64'hABC; #1;
    check("flush_ack", commit_ack_o, 1'b0);
    check("flush_we", we_o, 1'b0);
    check("flush_fr", flush_req_o, 1'b0);
    tick(); flush_i = 1'b0; csr_ack_i = 1'b0; head(3'd1, 5'd4, 64'h44); #1;
    check("after_flush_ack", commit_ack_o, 1'b1);
    check("after_flush_we", we_o, 1'b1);
    check("after_flush_instret", instret_o, 64'd5);

    // Halt does not abort a CSR already waiting.
    tick(); head(3'd4, 5'd8, 64'h0); #1;
    check("csr3_req", csr_commit_o, 1'b1);
    tick(); halt_i = 1'b1; csr_ack_i = 1'b1; csr_rdata_i = 64'h5A; #1;
    check("halt_csr_ack", commit_ack_o, 1'b1);
    check("halt_csr_wdata", wdata_o, 64'h5A);
    tick(); halt_i = 1'b0; csr_ack_i = 1'b0; commit_valid_i = 1'b0; #1;
    check("halt_csr_instret", instret_o, 64'd7);

    // Reset in the middle of a stalled store.
    tick(); head(3'd3, 5'd1, 64'h0); commit_store_ready_i = 1'b0; #1;
    check("st2_store", commit_store_o, 1'b1);
    tick(); rst_i = 1'b1; #1;
    check("rst_store", commit_store_o, 1'b0);
    check("rst_st_ack", commit_ack_o, 1'b0);
    tick(); rst_i = 1'b0; #1;
    check("post_rst_instret", instret_o, 64'd0);
    check("post_rst_store", commit_store_o, 1'b1);
    tick(); commit_store_ready_i = 1'b1; #1;
    check("post_rst_st_ack", commit_ack_o, 1'b1);
    tick(); commit_valid_i = 1'b0; commit_store_ready_i = 1'b0; #1;
    check("post_rst_instret1", instret_o, 64'd1);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
